// File: rtl/fifo_uart_tx.sv
// Drains first-word-fall-through FIFO words onto a UART line, least-significant byte first.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit after each byte's data bits.
module fifo_uart_tx #(
    parameter int data_width   = 16,
    parameter int clks_per_bit = 434
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [data_width-1:0] rdata,
    input  logic                  rempty,
    output logic                  rinc,
    output logic                  txd,
    output logic                  busy,
    output logic                  byte_done
);
    localparam int NBYTES = data_width / 8;
    localparam int BAUD_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state, state_n;
    logic [BAUD_W-1:0]       baud;
    logic [2:0]              bit_cnt;
    logic [BYTE_W-1:0]       byte_cnt;
    logic [data_width-1:0]   shreg;
    logic                    baud_last;
    logic                    last_byte;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    par;
`endif

    assign baud_last = (baud == BAUD_LAST);
    assign last_byte = (byte_cnt == BYTE_LAST);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= IDLE;
        else         state <= state_n;
    end

    // rinc is gated by reset so a non-empty FIFO is never popped while held in reset
    always_comb begin
        state_n   = state;
        rinc      = 1'b0;
        txd       = 1'b1;
        busy      = (state != IDLE);
        byte_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rempty && rrst_n) begin
                    rinc    = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (baud_last) state_n = DATA;
            end
            DATA: begin
                txd = shreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
                if (baud_last && bit_cnt == 3'd7) state_n = PARITY;
`else
                if (baud_last && bit_cnt == 3'd7) state_n = STOP;
`endif
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                txd = par;
                if (baud_last) state_n = STOP;
            end
`endif
            STOP: begin
                if (baud_last) begin
                    byte_done = 1'b1;
                    state_n   = last_byte ? IDLE : START;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Word shifts right one bit per data bit, so shreg[0] always holds the next bit on the wire
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            baud     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            if (state == IDLE || baud_last) baud <= '0;
            else                            baud <= baud + BAUD_W'(1);
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    if (!rempty) shreg <= rdata;
                end
`ifdef FIFO_UART_TX_PARITY_EN
                START: if (baud_last) par <= ^shreg[7:0];
`endif
                DATA: begin
                    if (baud_last) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    if (baud_last) byte_cnt <= last_byte ? '0 : byte_cnt + BYTE_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench: a queue-backed FWFT FIFO feeds the DUT; expected line levels per cycle
// are expanded from each popped word into a queue of (txd, byte_done) samples.
module tb_fifo_uart_tx;
    localparam int DW  = 16;
    localparam int CPB = 4;
    localparam int NB  = DW / 8;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic [DW-1:0] rdata;
    logic          rempty;
    logic          rinc, txd, busy, byte_done;

    fifo_uart_tx #(.data_width(DW), .clks_per_bit(CPB)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
        .rinc(rinc), .txd(txd), .busy(busy), .byte_done(byte_done)
    );

    always #5 rclk = ~rclk;

    typedef struct packed { logic lvl; logic bd; } smp_t;

    logic [DW-1:0] q[$];
    smp_t          exp_q[$];
    int            total = 0;
    int            bad   = 0;
    bit            popped = 0;
    bit            rnd    = 0;
    int            rinc_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, want, $time);
        end
    endtask

    task automatic push_lvl(input logic lvl, input int n, input bit bd_last);
        for (int i = 0; i < n; i++) begin
            smp_t s;
            s.lvl = lvl;
            s.bd  = bd_last && (i == n - 1);
            exp_q.push_back(s);
        end
    endtask

    task automatic build_frame(input logic [DW-1:0] w);
        for (int b = 0; b < NB; b++) begin
            logic [7:0] by;
            by = w[8*b +: 8];
            push_lvl(1'b0, CPB, 1'b0);
            for (int i = 0; i < 8; i++) push_lvl(by[i], CPB, 1'b0);
`ifdef FIFO_UART_TX_PARITY_EN
            push_lvl(^by, CPB, 1'b0);
`endif
            push_lvl(1'b1, CPB, 1'b1);
        end
    endtask

    // One negedge sample against the reference stream
    task automatic step();
        if (rinc === 1'b1) rinc_cnt++;
        if (exp_q.size() == 0) begin
            chk("idle_rinc", rinc, !rempty);
            chk("idle_txd", txd, 1);
            chk("idle_busy", busy, 0);
            chk("idle_bd", byte_done, 0);
            if (!rempty) build_frame(q[0]);
            popped = (rinc === 1'b1) && (q.size() > 0);
        end else begin
            smp_t s;
            s = exp_q.pop_front();
            chk("txd", txd, s.lvl);
            chk("busy", busy, 1);
            chk("byte_done", byte_done, s.bd);
            chk("rinc_busy", rinc, 0);
            popped = 1'b0;
        end
    endtask

    task automatic drive();
        rempty = (q.size() == 0);
        rdata  = (q.size() > 0) ? q[0] : DW'($urandom);
    endtask

    task automatic cycle();
        @(negedge rclk);
        step();
        @(posedge rclk);
        #1;
        if (popped) begin
            void'(q.pop_front());
            popped = 1'b0;
        end
        if (rnd && $urandom_range(0, 39) == 0) q.push_back(DW'($urandom));
        drive();
    endtask

    initial begin
        bit got;
        rrst_n = 1'b0;
        q.push_back(16'h1234);
        drive();
        // Non-empty FIFO during reset must not be popped
        repeat (3) begin
            @(negedge rclk);
            chk("rst_rinc", rinc, 0);
            chk("rst_txd", txd, 1);
            chk("rst_busy", busy, 0);
            chk("rst_bd", byte_done, 0);
        end
        q.delete();
        drive();
        @(posedge rclk);
        #2 rrst_n = 1'b1;

        // Long empty stretch: line stays idle
        repeat (1000) cycle();

        // Single word, then two back-to-back words
        q.push_back(16'hA55A);
        drive();
        repeat (100) cycle();
        rinc_cnt = 0;
        q.push_back(16'h0001);
        q.push_back(16'h00FF);
        drive();
        repeat (200) cycle();
        chk("b2b_rinc_cnt", rinc_cnt, 2);

        // Random traffic
        rnd = 1'b1;
        repeat (3000) cycle();
        rnd = 1'b0;
        repeat (200) cycle();

        // Reset mid-frame, during the first byte's data bits
        q.push_back(DW'($urandom));
        drive();
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            cycle();
            got = (exp_q.size() > 0);
        end
        chk("pop_seen", got, 1);
        repeat (8) cycle();
        chk("pre_rst_busy", busy, 1);
        q.push_back(16'hBEEF);
        drive();
        #2 rrst_n = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rinc", rinc, 0);
        chk("mid_rst_bd", byte_done, 0);
        exp_q.delete();
        popped = 1'b0;
        repeat (2) begin
            @(negedge rclk);
            chk("hold_rinc", rinc, 0);
            chk("hold_txd", txd, 1);
        end
        @(posedge rclk);
        #2 rrst_n = 1'b1;

        // Next word must be the one queued after the lost word
        rnd = 1'b1;
        repeat (1500) cycle();
        rnd = 1'b0;
        repeat (200) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
